// File: rtl/pb_event_ctrl_if.sv
// Valid/ready event port between the push-button controller and its consumer.
// The controller uses the master side; the consumer drives evt_ready.
interface pb_event_ctrl_if #(
    parameter int ID_W = 2
);
    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;
    logic            evt_long;

    modport master (
        output evt_valid,
        output evt_id,
        output evt_long,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        input  evt_long,
        output evt_ready
    );
endinterface

// File: rtl/pb_event_ctrl.sv
// Push-button event controller: sync, debounce, press/long detect per button,
// then a fixed-priority arbiter feeding one registered valid/ready event port.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | output register empty, evt_valid=0, loads any candidate
// S_SHOW   | event presented, held until evt_ready, then reloads
module pb_event_ctrl #(
    parameter int N          = 4,
    parameter int DIV        = 100000,
    parameter int DB_LEN     = 4,
    parameter int LONG_TICKS = 100,
    parameter int ID_W       = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    pb_in,
    output logic [N-1:0]    pressed,
    pb_event_ctrl_if.master evt
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam logic [PW-1:0] PRES_LAST = PW'(DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SHOW = 1'b1
    } state_t;

    logic [PW-1:0]     pres_q, pres_d;
    logic              tick;

    logic [N-1:0]      sync1_q, sync2_q;

    logic [DB_LEN-1:0] db_q   [N];
    logic [DB_LEN-1:0] db_d   [N];
    logic [HW-1:0]     hold_q [N];
    logic [HW-1:0]     hold_d [N];
    logic [N-1:0]      stable_q, stable_d;
    logic [N-1:0]      press_set, long_set;

    logic [N-1:0]      press_pend_q, press_pend_d;
    logic [N-1:0]      long_pend_q, long_pend_d;
    logic [N-1:0]      clr_press, clr_long;

    logic              win_found;
    logic [ID_W-1:0]   win_id;
    logic              win_long;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              long_q, long_d;
    logic              load;

    // Sample tick prescaler
    always_comb begin
        tick   = (pres_q == PRES_LAST);
        pres_d = tick ? '0 : pres_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pres_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            pres_q  <= pres_d;
            sync1_q <= pb_in;
            sync2_q <= sync1_q;
        end
    end

    // The counter only advances when the level was already high and stays high,
    // so the first long tick is one full tick after the accepted rising edge.
    always_comb begin
        logic [DB_LEN-1:0] sh;
        sh = '0;
        for (int i = 0; i < N; i++) begin
            db_d[i]      = db_q[i];
            stable_d[i]  = stable_q[i];
            hold_d[i]    = hold_q[i];
            press_set[i] = 1'b0;
            long_set[i]  = 1'b0;
            if (tick) begin
                sh      = {db_q[i][DB_LEN-2:0], sync2_q[i]};
                db_d[i] = sh;
                if (&sh) begin
                    stable_d[i] = 1'b1;
                end else if (~|sh) begin
                    stable_d[i] = 1'b0;
                end
                press_set[i] = stable_d[i] & ~stable_q[i];
                if (stable_q[i] && stable_d[i]) begin
                    if (hold_q[i] != HOLD_MAX) begin
                        hold_d[i]   = hold_q[i] + HW'(1);
                        long_set[i] = (hold_q[i] == HOLD_MAX - HW'(1));
                    end
                end else begin
                    hold_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                db_q[i]   <= '0;
                hold_q[i] <= '0;
            end
            stable_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                db_q[i]   <= db_d[i];
                hold_q[i] <= hold_d[i];
            end
            stable_q <= stable_d;
        end
    end

    // Set wins over a same-cycle clear; a repeated set merges into one event.
    always_comb begin
        press_pend_d = (press_pend_q & ~clr_press) | press_set;
        long_pend_d  = (long_pend_q  & ~clr_long)  | long_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_pend_q <= '0;
            long_pend_q  <= '0;
        end else begin
            press_pend_q <= press_pend_d;
            long_pend_q  <= long_pend_d;
        end
    end

    // Scan from the top so the lowest index is the last (winning) assignment.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_long  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (press_pend_q[i]) begin
                win_found = 1'b1;
                win_id    = ID_W'(i);
                win_long  = 1'b0;
            end else if (long_pend_q[i]) begin
                win_found = 1'b1;
                win_id    = ID_W'(i);
                win_long  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            long_q  <= long_d;
        end
    end

    always_comb begin
        load      = (state_q == S_IDLE) || evt.evt_ready;
        state_d   = state_q;
        id_d      = id_q;
        long_d    = long_q;
        clr_press = '0;
        clr_long  = '0;
        if (load) begin
            if (win_found) begin
                state_d = S_SHOW;
                id_d    = win_id;
                long_d  = win_long;
            end else begin
                state_d = S_IDLE;
                id_d    = '0;
                long_d  = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (load && win_found && (win_id == ID_W'(i))) begin
                clr_press[i] = ~win_long;
                clr_long[i]  = win_long;
            end
        end
    end

    always_comb begin
        evt.evt_valid = (state_q == S_SHOW);
        evt.evt_id    = id_q;
        evt.evt_long  = long_q;
        pressed       = stable_q;
    end

endmodule
